// File: rtl/ccd_capture_seq.sv
// Capture sequencer for the CCD timing generator: programs it over APB, enables it,
// counts synchronised frame starts and shuts it down after the requested frames.
module ccd_capture_seq #(
   parameter logic [23:0] SOF_TIMEOUT = 24'd12_000_000,
   parameter logic [15:0] DRAIN_GAP   = 16'd8192
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        continuous,
   input  logic [7:0]  num_frames,
   input  logic        cfg_embed_eshut,
   input  logic        cfg_start_eshut,
   input  logic [3:0]  cfg_vskip,
   input  logic [14:0] cfg_delay_h,
   input  logic [14:0] cfg_delay_v,
   input  logic [14:0] cfg_eshut_line,
   input  logic        dvp_vsync,
   input  logic        dvp_hsync,
   output logic        m_apb_psel,
   output logic        m_apb_penable,
   output logic        m_apb_pwrite,
   output logic [15:0] m_apb_paddr,
   output logic [31:0] m_apb_pwdata,
   input  logic        m_apb_pready,
   output logic        busy,
   output logic        done,
   output logic        frame_sof,
   output logic [7:0]  frame_cnt,
   output logic        err_timeout
);

   localparam logic [15:0] ADDR_CTRL    = 16'h0000;
   localparam logic [15:0] ADDR_DELAY_H = 16'h0004;
   localparam logic [15:0] ADDR_DELAY_V = 16'h0008;
   localparam logic [15:0] ADDR_ESHUT   = 16'h000C;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_WR_DH    = 4'd1,
      ST_WR_DV    = 4'd2,
      ST_WR_ES    = 4'd3,
      ST_WR_ON    = 4'd4,
      ST_WAIT_SOF = 4'd5,
      ST_WR_OFF   = 4'd6,
      ST_DRAIN    = 4'd7,
      ST_DONE     = 4'd8
   } state_t;

   state_t      state_r;
   logic        vs_meta_r, vs_sync_r, vs_prev_r;
   logic        hs_meta_r, hs_sync_r, hs_prev_r;
   logic        cont_r, embed_r, sest_r, abort_pend_r;
   logic [7:0]  nfr_r;
   logic [3:0]  vskip_r;
   logic [14:0] dh_r, dv_r, esl_r;
   logic [23:0] wd_cnt_r;
   logic [15:0] gap_cnt_r;

   logic        sof_s, line_s, last_s, abort_any_s, wd_expired_s, gap_done_s;
   logic [7:0]  target_s;

   // Generator CTRL register layout; output enables are always driven high.
   function automatic logic [31:0] ctrl_word(input logic en, input logic [3:0] vskip,
                                             input logic sest, input logic embed);
      return {22'd0, 1'b1, 1'b1, vskip, sest, embed, 1'b0, en};
   endfunction

   assign sof_s        = vs_prev_r & ~vs_sync_r;
   assign line_s       = hs_prev_r & ~hs_sync_r;
   assign target_s     = (nfr_r == 8'd0) ? 8'd1 : nfr_r;
   assign last_s       = ~cont_r & (({1'b0, frame_cnt} + 9'd1) == {1'b0, target_s});
   assign abort_any_s  = abort | abort_pend_r;
   assign wd_expired_s = (wd_cnt_r == (SOF_TIMEOUT - 24'd1));
   assign gap_done_s   = (gap_cnt_r == (DRAIN_GAP - 16'd1));

   // Two-flop synchronisers plus a history flop for falling-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_meta_r <= 1'b1;
         vs_sync_r <= 1'b1;
         vs_prev_r <= 1'b1;
         hs_meta_r <= 1'b1;
         hs_sync_r <= 1'b1;
         hs_prev_r <= 1'b1;
      end else begin
         vs_meta_r <= dvp_vsync;
         vs_sync_r <= vs_meta_r;
         vs_prev_r <= vs_sync_r;
         hs_meta_r <= dvp_hsync;
         hs_sync_r <= hs_meta_r;
         hs_prev_r <= hs_sync_r;
      end
   end

   // Capture sequencer FSM with APB master and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         m_apb_psel    <= 1'b0;
         m_apb_penable <= 1'b0;
         m_apb_pwrite  <= 1'b0;
         m_apb_paddr   <= 16'h0000;
         m_apb_pwdata  <= 32'h0000_0000;
         busy          <= 1'b0;
         done          <= 1'b0;
         frame_sof     <= 1'b0;
         frame_cnt     <= 8'd0;
         err_timeout   <= 1'b0;
         cont_r        <= 1'b0;
         embed_r       <= 1'b0;
         sest_r        <= 1'b0;
         abort_pend_r  <= 1'b0;
         nfr_r         <= 8'd0;
         vskip_r       <= 4'd0;
         dh_r          <= 15'd0;
         dv_r          <= 15'd0;
         esl_r         <= 15'd0;
         wd_cnt_r      <= 24'd0;
         gap_cnt_r     <= 16'd0;
      end else begin
         done      <= 1'b0;
         frame_sof <= sof_s && (state_r != ST_IDLE);
         if (abort && (state_r != ST_IDLE)) begin
            abort_pend_r <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  cont_r        <= continuous;
                  nfr_r         <= num_frames;
                  embed_r       <= cfg_embed_eshut;
                  sest_r        <= cfg_start_eshut;
                  vskip_r       <= cfg_vskip;
                  dh_r          <= cfg_delay_h;
                  dv_r          <= cfg_delay_v;
                  esl_r         <= cfg_eshut_line;
                  err_timeout   <= 1'b0;
                  frame_cnt     <= 8'd0;
                  busy          <= 1'b1;
                  abort_pend_r  <= 1'b0;
                  m_apb_psel    <= 1'b1;
                  m_apb_penable <= 1'b0;
                  m_apb_pwrite  <= 1'b1;
                  m_apb_paddr   <= ADDR_DELAY_H;
                  m_apb_pwdata  <= {17'd0, cfg_delay_h};
                  state_r       <= ST_WR_DH;
               end
            end
            ST_WR_DH, ST_WR_DV, ST_WR_ES, ST_WR_ON, ST_WR_OFF: begin
               if (!m_apb_penable) begin
                  m_apb_penable <= 1'b1;
               end else if (m_apb_pready) begin
                  // Back-to-back transfers go straight into the next setup phase.
                  m_apb_penable <= 1'b0;
                  if (state_r == ST_WR_OFF) begin
                     m_apb_psel <= 1'b0;
                     gap_cnt_r  <= 16'd0;
                     state_r    <= ST_DRAIN;
                  end else if (abort_any_s) begin
                     m_apb_paddr  <= ADDR_CTRL;
                     m_apb_pwdata <= ctrl_word(1'b0, vskip_r, sest_r, embed_r);
                     abort_pend_r <= 1'b0;
                     state_r      <= ST_WR_OFF;
                  end else if (state_r == ST_WR_DH) begin
                     m_apb_paddr  <= ADDR_DELAY_V;
                     m_apb_pwdata <= {17'd0, dv_r};
                     state_r      <= ST_WR_DV;
                  end else if (state_r == ST_WR_DV) begin
                     m_apb_paddr  <= ADDR_ESHUT;
                     m_apb_pwdata <= {17'd0, esl_r};
                     state_r      <= ST_WR_ES;
                  end else if (state_r == ST_WR_ES) begin
                     m_apb_paddr  <= ADDR_CTRL;
                     m_apb_pwdata <= ctrl_word(1'b1, vskip_r, sest_r, embed_r);
                     state_r      <= ST_WR_ON;
                  end else begin
                     m_apb_psel <= 1'b0;
                     wd_cnt_r   <= 24'd0;
                     state_r    <= ST_WAIT_SOF;
                  end
               end
            end
            ST_WAIT_SOF: begin
               if (sof_s) begin
                  wd_cnt_r <= 24'd0;
                  if (frame_cnt != 8'd255) begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end else begin
                  wd_cnt_r <= wd_cnt_r + 24'd1;
               end
               if ((sof_s && last_s) || abort_any_s || (!sof_s && wd_expired_s)) begin
                  if (!sof_s && wd_expired_s) begin
                     err_timeout <= 1'b1;
                  end
                  m_apb_psel    <= 1'b1;
                  m_apb_penable <= 1'b0;
                  m_apb_paddr   <= ADDR_CTRL;
                  m_apb_pwdata  <= ctrl_word(1'b0, vskip_r, sest_r, embed_r);
                  abort_pend_r  <= 1'b0;
                  state_r       <= ST_WR_OFF;
               end
            end
            ST_DRAIN: begin
               if (line_s) begin
                  gap_cnt_r <= 16'd0;
               end else if (gap_done_s) begin
                  done    <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  gap_cnt_r <= gap_cnt_r + 16'd1;
               end
            end
            ST_DONE: begin
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               m_apb_psel    <= 1'b0;
               m_apb_penable <= 1'b0;
               busy          <= 1'b0;
               state_r       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ccd_capture_seq.sv
// Randomised bench for ccd_capture_seq: APB slave with programmable stalls, vsync/hsync
// drivers and a rule-based model of the expected register writes and frame counts.
module tb_ccd_capture_seq;

   localparam logic [23:0] TO  = 24'd3000;
   localparam logic [15:0] GAP = 16'd200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, abort = 1'b0, continuous = 1'b0;
   logic [7:0]  num_frames = 8'd0;
   logic        cfg_embed_eshut = 1'b0, cfg_start_eshut = 1'b0;
   logic [3:0]  cfg_vskip = 4'd0;
   logic [14:0] cfg_delay_h = 15'd0, cfg_delay_v = 15'd0, cfg_eshut_line = 15'd0;
   logic        dvp_vsync = 1'b1, dvp_hsync = 1'b1;
   logic        m_apb_psel, m_apb_penable, m_apb_pwrite;
   logic [15:0] m_apb_paddr;
   logic [31:0] m_apb_pwdata;
   logic        m_apb_pready = 1'b0;
   logic        busy, done, frame_sof, err_timeout;
   logic [7:0]  frame_cnt;

   int n_checks = 0, n_errors = 0;
   int cyc = 0, stall_n = 0;
   int done_cnt = 0, sof_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
   int waited = 0;
   logic prev_setup = 1'b0, in_access = 1'b0;
   logic [15:0] acc_addr = 16'h0;
   logic [31:0] acc_data = 32'h0;
   logic [15:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];
   logic        c_embed = 1'b0, c_sest = 1'b0;
   logic [3:0]  c_vskip = 4'd0;
   logic [14:0] c_dh = 15'd0, c_dv = 15'd0, c_es = 15'd0;

   ccd_capture_seq #(.SOF_TIMEOUT(TO), .DRAIN_GAP(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .continuous(continuous),
      .num_frames(num_frames), .cfg_embed_eshut(cfg_embed_eshut),
      .cfg_start_eshut(cfg_start_eshut), .cfg_vskip(cfg_vskip), .cfg_delay_h(cfg_delay_h),
      .cfg_delay_v(cfg_delay_v), .cfg_eshut_line(cfg_eshut_line), .dvp_vsync(dvp_vsync),
      .dvp_hsync(dvp_hsync), .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable),
      .m_apb_pwrite(m_apb_pwrite), .m_apb_paddr(m_apb_paddr), .m_apb_pwdata(m_apb_pwdata),
      .m_apb_pready(m_apb_pready), .busy(busy), .done(done), .frame_sof(frame_sof),
      .frame_cnt(frame_cnt), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] exp_ctrl(input logic en);
      return 32'h300 + (32'(c_vskip) * 32'd16) + (32'(c_sest) * 32'd8)
             + (32'(c_embed) * 32'd4) + 32'(en);
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // pulse counters, sampled on the falling edge
   initial forever begin
      @(negedge clk);
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (frame_sof) sof_cnt++;
   end

   // APB slave: stalls each access stall_n cycles, logs completed writes
   initial forever begin
      @(negedge clk);
      m_apb_pready = 1'b0;
      if (!rst_n) begin
         waited = 0;
         in_access = 1'b0;
         prev_setup = 1'b0;
      end else begin
         if (m_apb_psel && m_apb_penable) begin
            if (!in_access) begin
               check_eq("apb_setup_before_access", 32'(prev_setup), 32'd1);
               acc_addr = m_apb_paddr;
               acc_data = m_apb_pwdata;
               in_access = 1'b1;
               waited = 0;
            end
            if (waited >= stall_n) begin
               m_apb_pready = 1'b1;
               check_eq("apb_pwrite", 32'(m_apb_pwrite), 32'd1);
               if (stall_n > 0) begin
                  check_eq("apb_paddr_stable", 32'(m_apb_paddr), 32'(acc_addr));
                  check_eq("apb_pwdata_stable", m_apb_pwdata, acc_data);
               end
               wr_addr.push_back(m_apb_paddr);
               wr_data.push_back(m_apb_pwdata);
               wr_cyc.push_back(cyc);
               in_access = 1'b0;
            end else begin
               waited++;
            end
         end
         prev_setup = m_apb_psel && !m_apb_penable;
      end
   end

   task automatic set_cfg(input logic [7:0] nf, input logic cont);
      c_embed = 1'($urandom_range(0, 1));
      c_sest  = 1'($urandom_range(0, 1));
      c_vskip = 4'($urandom_range(0, 15));
      c_dh    = 15'($urandom);
      c_dv    = 15'($urandom);
      c_es    = 15'($urandom);
      num_frames = nf;
      continuous = cont;
      cfg_embed_eshut = c_embed;
      cfg_start_eshut = c_sest;
      cfg_vskip = c_vskip;
      cfg_delay_h = c_dh;
      cfg_delay_v = c_dv;
      cfg_eshut_line = c_es;
      stall_n = 0;
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
   endtask

   // new values after start must have no effect on the running capture
   task automatic scramble_cfg();
      num_frames = 8'($urandom);
      continuous = 1'($urandom_range(0, 1));
      cfg_embed_eshut = 1'($urandom_range(0, 1));
      cfg_start_eshut = 1'($urandom_range(0, 1));
      cfg_vskip = 4'($urandom);
      cfg_delay_h = 15'($urandom);
      cfg_delay_v = 15'($urandom);
      cfg_eshut_line = 15'($urandom);
   endtask

   task automatic pulse_start(input logic with_abort);
      @(negedge clk);
      start = 1'b1;
      abort = with_abort;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic pulse_abort();
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   task automatic vsync_pulse();
      @(negedge clk);
      dvp_vsync = 1'b0;
      repeat (4) @(negedge clk);
      dvp_vsync = 1'b1;
      repeat (36) @(negedge clk);
   endtask

   task automatic hsync_burst(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         dvp_hsync = 1'b0;
         last_hs_cyc = cyc;
         repeat (2) @(negedge clk);
         dvp_hsync = 1'b1;
         repeat (48) @(negedge clk);
      end
   endtask

   task automatic wait_writes(input int n, input int budget);
      int t = 0;
      while (wr_addr.size() < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      check_eq("writes_reached", 32'(wr_addr.size() >= n), 32'd1);
   endtask

   task automatic wait_done(input int base, input int budget, input string tag);
      int t = 0;
      while (done_cnt <= base && t < budget) begin
         @(negedge clk);
         t++;
      end
      check_eq(tag, 32'(done_cnt > base), 32'd1);
      repeat (5) @(negedge clk);
      check_eq({tag, "_once"}, 32'(done_cnt - base), 32'd1);
      check_eq({tag, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   // mode 0: full program/ON/OFF sequence, mode 1: abort right after DELAY_VTIME
   task automatic check_writes(input string tag, input int mode);
      logic [15:0] ea[$];
      logic [31:0] ed[$];
      ea = {16'h0004, 16'h0008};
      ed = {32'(c_dh), 32'(c_dv)};
      if (mode == 0) begin
         ea.push_back(16'h000C);
         ed.push_back(32'(c_es));
         ea.push_back(16'h0000);
         ed.push_back(exp_ctrl(1'b1));
      end
      ea.push_back(16'h0000);
      ed.push_back(exp_ctrl(1'b0));
      check_eq({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(ea.size()));
      for (int i = 0; i < ea.size() && i < wr_addr.size(); i++) begin
         check_eq($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(ea[i]));
         check_eq($sformatf("%s_data%0d", tag, i), wr_data[i], ed[i]);
      end
   endtask

   task automatic run_normal(input logic [7:0] nf, input int stall, input logic with_abort,
                             input logic restart_probe);
      int d0, s0, nexp, lat;
      set_cfg(nf, 1'b0);
      stall_n = stall;
      d0 = done_cnt;
      s0 = sof_cnt;
      pulse_start(with_abort);
      scramble_cfg();
      check_eq("busy_after_start", 32'(busy), 32'd1);
      check_eq("err_cleared_by_start", 32'(err_timeout), 32'd0);
      wait_writes(4, 100);
      for (int i = 1; i < 4 && i < wr_cyc.size(); i++)
         check_eq("write_spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'(2 + stall));
      if (restart_probe) pulse_start(1'b0);
      repeat (8) @(negedge clk);
      nexp = (nf == 8'd0) ? 1 : int'(nf);
      repeat (nexp + 1) vsync_pulse();
      hsync_burst(6);
      wait_done(d0, int'(GAP) + 100, "done_normal");
      lat = done_cyc - last_hs_cyc;
      check_eq("drain_latency", 32'(lat >= int'(GAP) && lat <= int'(GAP) + 4), 32'd1);
      check_eq("frame_cnt_normal", 32'(frame_cnt), 32'(nexp));
      check_eq("sof_pulses_normal", 32'(sof_cnt - s0), 32'(nexp + 1));
      check_writes("normal", 0);
   endtask

   task automatic run_continuous();
      int d0, s0;
      set_cfg(8'd1, 1'b1);
      stall_n = 1;
      d0 = done_cnt;
      s0 = sof_cnt;
      pulse_start(1'b0);
      scramble_cfg();
      wait_writes(4, 100);
      repeat (8) @(negedge clk);
      repeat (5) vsync_pulse();
      check_eq("cont_still_busy", 32'(busy), 32'd1);
      check_eq("cont_frame_cnt_mid", 32'(frame_cnt), 32'd5);
      pulse_abort();
      hsync_burst(3);
      wait_done(d0, int'(GAP) + 100, "done_cont");
      check_eq("cont_frame_cnt", 32'(frame_cnt), 32'd5);
      check_eq("cont_sof_pulses", 32'(sof_cnt - s0), 32'd5);
      check_writes("cont", 0);
   endtask

   task automatic run_timeout();
      int d0, t0, t, lat;
      set_cfg(8'd1, 1'b0);
      d0 = done_cnt;
      pulse_start(1'b0);
      scramble_cfg();
      wait_writes(4, 100);
      t0 = (wr_cyc.size() >= 4) ? wr_cyc[3] : cyc;
      t = 0;
      while (!err_timeout && t < int'(TO) + 100) begin
         @(negedge clk);
         t++;
      end
      lat = cyc - t0;
      check_eq("timeout_flag", 32'(err_timeout), 32'd1);
      check_eq("timeout_latency", 32'(lat >= int'(TO) && lat <= int'(TO) + 4), 32'd1);
      wait_done(d0, int'(GAP) + 100, "done_timeout");
      check_eq("timeout_sticky", 32'(err_timeout), 32'd1);
      check_eq("timeout_frame_cnt", 32'(frame_cnt), 32'd0);
      check_writes("timeout", 0);
   endtask

   task automatic run_abort_dv();
      int d0, t;
      set_cfg(8'd2, 1'b0);
      stall_n = 3;
      d0 = done_cnt;
      pulse_start(1'b0);
      scramble_cfg();
      t = 0;
      while (!(m_apb_psel && m_apb_penable && m_apb_paddr == 16'h0008) && t < 100) begin
         @(negedge clk);
         t++;
      end
      check_eq("reach_dv_access", 32'(t < 100), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done(d0, int'(GAP) + 100, "done_abort_dv");
      check_eq("abort_dv_frame_cnt", 32'(frame_cnt), 32'd0);
      check_writes("abort_dv", 1);
   endtask

   task automatic run_reset_wait_sof();
      int d0;
      set_cfg(8'd3, 1'b0);
      pulse_start(1'b0);
      scramble_cfg();
      wait_writes(4, 100);
      repeat (8) @(negedge clk);
      vsync_pulse();
      check_eq("pre_reset_frame_cnt", 32'(frame_cnt), 32'd1);
      d0 = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_mid_flags", 32'({busy, m_apb_psel, m_apb_penable, m_apb_pwrite, done,
                                     frame_sof, err_timeout}), 32'd0);
      check_eq("rst_mid_frame_cnt", 32'(frame_cnt), 32'd0);
      check_eq("rst_mid_pwdata", m_apb_pwdata, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (int'(GAP) + 50) @(negedge clk);
      check_eq("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
      check_eq("idle_after_reset", 32'(busy), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_eq("reset_flags", 32'({busy, m_apb_psel, m_apb_penable, m_apb_pwrite, done,
                                   frame_sof, err_timeout}), 32'd0);
      check_eq("reset_frame_cnt", 32'(frame_cnt), 32'd0);
      check_eq("reset_paddr", 32'(m_apb_paddr), 32'd0);
      check_eq("reset_pwdata", m_apb_pwdata, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      wr_addr.delete();
      pulse_abort();
      repeat (5) @(negedge clk);
      check_eq("abort_idle_no_writes", 32'(wr_addr.size()), 32'd0);
      check_eq("abort_idle_not_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 5; i++) begin
         logic [7:0] nf;
         int st;
         nf = (i == 0) ? 8'd2 : (i == 1) ? 8'd0 : 8'($urandom_range(1, 4));
         st = (i == 0) ? 0 : (i == 2) ? 3 : int'($urandom_range(0, 3));
         run_normal(nf, st, i == 1, i == 3);
      end
      run_continuous();
      run_timeout();
      run_normal(8'($urandom_range(1, 3)), 1, 1'b0, 1'b0);
      run_abort_dv();
      run_reset_wait_sof();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
